uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_BITS SHALL be declared with default 8 and legal range 5..9; it sets the payload bits per frame.
REQ-002 Parameter CLKS_PER_BIT SHALL be declared with default 868 and minimum 2; it sets the clock cycles per serial bit.
REQ-003 clock  input  1  the single system clock; all logic SHALL be on its rising edge.
REQ-004 reset_n  input  1  the reset; it SHALL be asynchronous and active-low.
REQ-005 tx_valid  input  1  SHALL indicate that a frame request is present.
REQ-006 tx_data  input  DATA_BITS  SHALL carry the payload, sampled when accepted.
REQ-007 parity_mode  input  2  SHALL select 00 none, 01 even, 10 odd, 11 none; sampled when accepted.
REQ-008 stop_two  input  1  SHALL select 0 one stop bit, 1 two stop bits; sampled when accepted.
REQ-009 tx_ready  output  1  SHALL be high only when a request can be accepted.
REQ-010 tx_serial  output  1  the serial line; it SHALL idle high.
REQ-011 tx_busy  output  1  SHALL be high while a frame is in progress.
REQ-012 tx_done  output  1  SHALL pulse for one cycle when a frame ends.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, and SHALL be registered.
REQ-014 Accept SHALL mean tx_valid and tx_ready both high on a rising edge; tx_ready SHALL equal (state==IDLE).
REQ-015 On accept, the block SHALL latch tx_data, parity_mode and stop_two into frame registers; input changes during a frame SHALL have no effect.
REQ-016 IDLE SHALL go to START on accept; tx_serial SHALL drive 0 from the cycle after accept (latency 1).
REQ-017 A bit timer SHALL count 0..CLKS_PER_BIT-1; each bit SHALL last exactly CLKS_PER_BIT cycles, and the timer SHALL wrap to 0 at every bit boundary.
REQ-018 START SHALL go to DATA after one bit time.
REQ-019 DATA SHALL shift the payload out LSB first, using a bit index of 0..DATA_BITS-1.
REQ-020 After the last data bit, DATA SHALL go to PARITY when the latched mode is even or odd, and to STOP otherwise.
REQ-021 Parity bit SHALL be the XOR of all DATA_BITS payload bits for even mode, and its inverse for odd mode.
REQ-022 STOP SHALL drive 1 for one bit time, or for two bit times when stop_two was latched high.
REQ-023 tx_done SHALL pulse on the final cycle of STOP, and the FSM SHALL then return to IDLE.
REQ-024 tx_ready SHALL be high on the cycle after tx_done, so back-to-back frames are separated by exactly one idle cycle (line high).
REQ-025 Frame length SHALL be (1 + DATA_BITS + P + S) * CLKS_PER_BIT cycles, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
REQ-026 tx_busy SHALL equal (state != IDLE).
REQ-027 tx_valid held high with tx_ready low SHALL neither corrupt the current frame nor queue a request.
REQ-028 Any undefined state encoding SHALL recover to IDLE with tx_serial = 1.

Reset
REQ-029 On reset_n low, the block SHALL immediately and asynchronously force: state IDLE, tx_serial 1, tx_ready 1, tx_busy 0, tx_done 0, timer 0, bit index 0, frame registers 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame, and the line SHALL return high without a stop bit or tx_done.
REQ-031 After reset_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-032 The state encodings and the parity_mode codes (PAR_NONE, PAR_EVEN, PAR_ODD) SHALL reside in the shared package uart_pkg, for reuse by the matching receiver.
REQ-033 The bit timer SHALL be a sub-module uart_baud_tick (parameter CLKS_PER_BIT; inputs clear and enable; output tick on the terminal count).
REQ-034 Timer and bit-index widths SHALL be $clog2-derived, with no truncation at maximum parameter values.

Verification (DATA_BITS=8, CLKS_PER_BIT=4)
REQ-035 tx_data 0x55, mode none, 1 stop -> line 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx_done after 40 cycles.
REQ-036 tx_data 0x07, even -> parity bit 1; odd -> parity bit 0; frame length 44 cycles.
REQ-037 stop_two=1, 0xFF, none -> line high for 8 cycles of stop; tx_done at cycle 44.
REQ-038 tx_valid held high for 3 frames -> tx_ready high 1 cycle between frames; exactly 1 idle-high cycle between frames.
REQ-039 reset_n low at cycle 17 of a frame -> tx_serial 1 in the same cycle; no tx_done; next accept starts a clean frame.
REQ-040 tx_data and parity_mode changed mid-frame -> the serial pattern is unchanged from the values latched at accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode codes used by TX and RX.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic parity_enabled(logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Odd parity inverts the XOR reduction of the payload.
    function automatic logic parity_bit(logic [1:0] mode, logic payload_xor);
        return (mode == PAR_ODD) ? ~payload_xor : payload_xor;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868,
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    assign tick = enable && (count == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, optional even/odd parity, one or two stop bits.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_two,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] data_q;
    logic [1:0]           mode_q;
    logic                 two_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     next_idx;
    logic                 stop_idx_q;
    logic                 stop_last;
    logic                 tick;
    logic [CNT_W-1:0]     count;

    assign tx_ready  = (state_q == StIdle);
    assign tx_busy   = (state_q != StIdle);
    assign next_idx  = bit_idx_q + IDX_W'(1);
    assign stop_last = (stop_idx_q == two_q);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (tx_ready),
        .enable (tx_busy),
        .tick   (tick),
        .count  (count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            tx_serial  <= 1'b1;
            tx_done    <= 1'b0;
            data_q     <= '0;
            mode_q     <= PAR_NONE;
            two_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tx_serial  <= 1'b1;
                    bit_idx_q  <= '0;
                    stop_idx_q <= 1'b0;
                    if (tx_valid) begin
                        data_q    <= tx_data;
                        mode_q    <= parity_mode;
                        two_q     <= stop_two;
                        state_q   <= StStart;
                        tx_serial <= 1'b0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        state_q   <= StData;
                        tx_serial <= data_q[0];
                    end
                end
                StData: begin
                    if (tick) begin
                        if (bit_idx_q == LAST_BIT) begin
                            bit_idx_q <= '0;
                            if (parity_enabled(mode_q)) begin
                                state_q   <= StParity;
                                tx_serial <= parity_bit(mode_q, ^data_q);
                            end else begin
                                state_q   <= StStop;
                                tx_serial <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= next_idx;
                            tx_serial <= data_q[next_idx];
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        state_q   <= StStop;
                        tx_serial <= 1'b1;
                    end
                end
                StStop: begin
                    // Registered pulse: raise it one cycle early so it lands on the final cycle.
                    if (stop_last && (count == PRE_LAST)) begin
                        tx_done <= 1'b1;
                    end
                    if (tick) begin
                        if (stop_last) begin
                            state_q    <= StIdle;
                            stop_idx_q <= 1'b0;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg against a per-cycle line model built from frame rules.
module tb_uart_tx_cfg;

    localparam int unsigned DB  = 8;
    localparam int unsigned CPB = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop_two = 1'b0;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    bit exp_q[$];   // expected line value for each remaining frame cycle
    bit bits_q[$];
    bit line_s[0:63];
    int frame_n;

    uart_tx_cfg #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .parity_mode(parity_mode),
        .stop_two   (stop_two),
        .tx_ready   (tx_ready),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clock = ~clock;

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: on accept, expand the whole frame into one entry per clock cycle.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (tx_valid) begin
            bits_q.delete();
            bits_q.push_back(1'b0);
            for (int i = 0; i < DB; i++) bits_q.push_back(tx_data[i]);
            if (parity_mode == 2'b01) bits_q.push_back(^tx_data);
            if (parity_mode == 2'b10) bits_q.push_back(~^tx_data);
            bits_q.push_back(1'b1);
            if (stop_two) bits_q.push_back(1'b1);
            foreach (bits_q[i]) begin
                for (int c = 0; c < CPB; c++) exp_q.push_back(bits_q[i]);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                check_bit("idle_serial", tx_serial, 1'b1);
                check_bit("idle_ready", tx_ready, 1'b1);
                check_bit("idle_busy", tx_busy, 1'b0);
                check_bit("idle_done", tx_done, 1'b0);
            end else begin
                check_bit("frame_serial", tx_serial, exp_q[0]);
                check_bit("frame_ready", tx_ready, 1'b0);
                check_bit("frame_busy", tx_busy, 1'b1);
                check_bit("frame_done", tx_done, exp_q.size() == 1);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the tx_done cycle.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] m, input logic two,
                             input int exp_len);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        tx_valid = 1'b1;
        tx_data = d;
        parity_mode = m;
        stop_two = two;
        @(negedge clock);
        // Scramble inputs mid-frame; the frame must follow the latched values.
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        parity_mode = 2'($urandom);
        stop_two = 1'($urandom);
        check_int("model_len", exp_q.size(), exp_len);
        frame_n = 1;
        while (tx_done !== 1'b1 && frame_n < 64) begin
            line_s[frame_n-1] = tx_serial;
            @(negedge clock);
            frame_n++;
        end
        line_s[frame_n-1] = tx_serial;
        check_int("frame_len", frame_n, exp_len);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat55;
        int dones;
        int rdy;
        int n;
        pat55 = 10'b1010101010;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_bit("rst_serial", tx_serial, 1'b1);
        check_bit("rst_ready", tx_ready, 1'b1);
        check_bit("rst_busy", tx_busy, 1'b0);
        check_bit("rst_done", tx_done, 1'b0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);

        // 0x55, no parity, one stop
        run_frame(8'h55, 2'b00, 1'b0, 40);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 4; c++) check_bit("pat55", line_s[4*k+c], pat55[k]);
        end

        // 0x07 even then odd parity
        run_frame(8'h07, 2'b01, 1'b0, 44);
        check_bit("par_even", line_s[36], 1'b1);
        check_bit("par_even_end", line_s[39], 1'b1);
        run_frame(8'h07, 2'b10, 1'b0, 44);
        check_bit("par_odd", line_s[36], 1'b0);
        check_bit("par_odd_end", line_s[39], 1'b0);

        // Two stop bits
        run_frame(8'hFF, 2'b11, 1'b1, 44);
        check_bit("stop2_start", line_s[0], 1'b0);
        for (int i = 36; i < 44; i++) check_bit("stop2_high", line_s[i], 1'b1);

        // Back-to-back: tx_valid held for three frames with churning inputs
        while (exp_q.size() != 0) @(negedge clock);
        tx_valid = 1'b1;
        @(negedge clock);
        dones = 0;
        rdy = 0;
        n = 0;
        while (dones < 3 && n < 300) begin
            if (tx_ready === 1'b1) rdy++;
            if (tx_done === 1'b1) dones++;
            if (dones == 3) tx_valid = 1'b0;
            tx_data = 8'($urandom);
            parity_mode = 2'($urandom);
            stop_two = 1'($urandom);
            @(negedge clock);
            n++;
        end
        tx_valid = 1'b0;
        check_int("b2b_dones", dones, 3);
        check_int("b2b_ready_cycles", rdy, 2);

        // Reset in cycle 17 of a frame
        while (exp_q.size() != 0) @(negedge clock);
        tx_valid = 1'b1;
        tx_data = 8'hA3;
        parity_mode = 2'b01;
        stop_two = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        repeat (16) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_bit("midrst_serial", tx_serial, 1'b1);
        check_bit("midrst_busy", tx_busy, 1'b0);
        check_bit("midrst_done", tx_done, 1'b0);
        @(negedge clock);
        check_bit("midrst_done2", tx_done, 1'b0);
        reset_n = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h55;
        parity_mode = 2'b00;
        stop_two = 1'b0;
        @(negedge clock);
        tx_valid = 1'b0;
        check_bit("post_rst_start", tx_serial, 1'b0);
        check_int("post_rst_len", exp_q.size(), 40);
        n = 1;
        while (tx_done !== 1'b1 && n < 64) begin
            @(negedge clock);
            n++;
        end
        check_int("post_rst_frame", n, 40);

        // Randomized traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clock);
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data = 8'($urandom);
            parity_mode = 2'($urandom);
            stop_two = 1'($urandom);
        end
        tx_valid = 1'b0;
        repeat (60) @(negedge clock);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
